// File: rtl/rv32i_alu_issue.sv
// RV32I decode/issue stage: decodes one instruction per cycle into a registered ALU bundle.
// Optional define RV32I_ISSUE_BYPASS_EN adds a writeback bypass (wb_wen/wb_rd/wb_data) onto rs1/rs2.
module rv32i_alu_issue #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
`ifdef RV32I_ISSUE_BYPASS_EN
    input  logic            wb_wen,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
`endif
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [OPW-1:0]  ex_op,
    output logic [XLEN-1:0] ex_in1,
    output logic [XLEN-1:0] ex_in2,
    output logic [4:0]      ex_rd,
    output logic            ex_wen,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic [XLEN-1:0] ex_tgt,
    output logic [XLEN-1:0] ex_pc,
    output logic            ex_illegal
);

    localparam logic [OPW-1:0] OP_ADD  = 4'd0;
    localparam logic [OPW-1:0] OP_SLL  = 4'd1;
    localparam logic [OPW-1:0] OP_XOR  = 4'd4;
    localparam logic [OPW-1:0] OP_SRL  = 4'd5;
    localparam logic [OPW-1:0] OP_OR   = 4'd6;
    localparam logic [OPW-1:0] OP_AND  = 4'd7;
    localparam logic [OPW-1:0] OP_SEQ  = 4'd8;
    localparam logic [OPW-1:0] OP_SNE  = 4'd9;
    localparam logic [OPW-1:0] OP_SUB  = 4'd10;
    localparam logic [OPW-1:0] OP_SRA  = 4'd11;
    localparam logic [OPW-1:0] OP_SLT  = 4'd12;
    localparam logic [OPW-1:0] OP_SGE  = 4'd13;
    localparam logic [OPW-1:0] OP_SLTU = 4'd14;
    localparam logic [OPW-1:0] OP_SGEU = 4'd15;

    typedef struct packed {
        logic [OPW-1:0]  op;
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [4:0]      rd;
        logic            wen;
        logic            branch;
        logic            jump;
        logic [XLEN-1:0] tgt;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } bundle_t;

    function automatic logic [OPW-1:0] f3_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return OP_SRL;
            3'b110:  return OP_OR;
            3'b111:  return OP_AND;
            default: return OP_ADD;
        endcase
    endfunction

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [XLEN-1:0] imm_i_s, imm_b_s, imm_j_s, imm_u_s, shamt_s, jalr_sum_s;
    logic [XLEN-1:0] src1_s, src2_s;
    logic            legal_s, transfer_s;
    bundle_t         dec_s, ex_d, ex_q;
    logic            ex_valid_d, ex_valid_q;

    assign opcode_s = if_inst[6:0];
    assign funct3_s = if_inst[14:12];
    assign funct7_s = if_inst[31:25];
    assign rs1_addr = if_inst[19:15];
    assign rs2_addr = if_inst[24:20];
    assign imm_i_s  = {{(XLEN-12){if_inst[31]}}, if_inst[31:20]};
    assign imm_b_s  = {{(XLEN-13){if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
    assign imm_j_s  = {{(XLEN-21){if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};
    assign imm_u_s  = {{(XLEN-32){if_inst[31]}}, if_inst[31:12], 12'h000};
    assign shamt_s  = {{(XLEN-5){1'b0}}, if_inst[24:20]};
    assign jalr_sum_s = src1_s + imm_i_s;

`ifdef RV32I_ISSUE_BYPASS_EN
    // Forward the writeback value when it targets a source register read this cycle
    always_comb begin
        src1_s = rs1_data;
        src2_s = rs2_data;
        if (wb_wen && (wb_rd != 5'd0) && (wb_rd == rs1_addr)) begin
            src1_s = wb_data;
        end else begin
            src1_s = rs1_data;
        end
        if (wb_wen && (wb_rd != 5'd0) && (wb_rd == rs2_addr)) begin
            src2_s = wb_data;
        end else begin
            src2_s = rs2_data;
        end
    end
`else
    assign src1_s = rs1_data;
    assign src2_s = rs2_data;
`endif

    // Instruction decode into the next ALU bundle
    always_comb begin
        dec_s    = '0;
        legal_s  = 1'b1;
        dec_s.rd = if_inst[11:7];
        dec_s.pc = if_pc;
        dec_s.op = OP_ADD;
        case (opcode_s)
            7'b0110011: begin
                dec_s.in1 = src1_s;
                dec_s.in2 = src2_s;
                dec_s.wen = 1'b1;
                if (funct7_s == 7'b0000000) begin
                    dec_s.op = f3_op(funct3_s);
                end else if (funct7_s == 7'b0100000 && funct3_s == 3'b000) begin
                    dec_s.op = OP_SUB;
                end else if (funct7_s == 7'b0100000 && funct3_s == 3'b101) begin
                    dec_s.op = OP_SRA;
                end else begin
                    legal_s = 1'b0;
                end
            end
            7'b0010011: begin
                dec_s.in1 = src1_s;
                dec_s.wen = 1'b1;
                dec_s.op  = f3_op(funct3_s);
                // Shift-immediates carry only the 5-bit shamt as operand 2
                if (funct3_s == 3'b001) begin
                    dec_s.in2 = shamt_s;
                    legal_s   = (funct7_s == 7'b0000000);
                end else if (funct3_s == 3'b101) begin
                    dec_s.in2 = shamt_s;
                    if (funct7_s == 7'b0000000) begin
                        dec_s.op = OP_SRL;
                    end else if (funct7_s == 7'b0100000) begin
                        dec_s.op = OP_SRA;
                    end else begin
                        legal_s = 1'b0;
                    end
                end else begin
                    dec_s.in2 = imm_i_s;
                end
            end
            7'b0110111: begin
                dec_s.in2 = imm_u_s;
                dec_s.wen = 1'b1;
            end
            7'b0010111: begin
                dec_s.in1 = if_pc;
                dec_s.in2 = imm_u_s;
                dec_s.wen = 1'b1;
            end
            7'b1100011: begin
                dec_s.in1    = src1_s;
                dec_s.in2    = src2_s;
                dec_s.branch = 1'b1;
                dec_s.tgt    = if_pc + imm_b_s;
                case (funct3_s)
                    3'b000:  dec_s.op = OP_SEQ;
                    3'b001:  dec_s.op = OP_SNE;
                    3'b100:  dec_s.op = OP_SLT;
                    3'b101:  dec_s.op = OP_SGE;
                    3'b110:  dec_s.op = OP_SLTU;
                    3'b111:  dec_s.op = OP_SGEU;
                    default: legal_s  = 1'b0;
                endcase
            end
            7'b1101111: begin
                dec_s.in1  = if_pc;
                dec_s.in2  = {{(XLEN-3){1'b0}}, 3'd4};
                dec_s.wen  = 1'b1;
                dec_s.jump = 1'b1;
                dec_s.tgt  = if_pc + imm_j_s;
            end
            7'b1100111: begin
                dec_s.in1  = if_pc;
                dec_s.in2  = {{(XLEN-3){1'b0}}, 3'd4};
                dec_s.wen  = 1'b1;
                dec_s.jump = 1'b1;
                dec_s.tgt  = {jalr_sum_s[XLEN-1:1], 1'b0};
                legal_s    = (funct3_s == 3'b000);
            end
            default: legal_s = 1'b0;
        endcase
        // Undecodable instructions still issue, but as an inert ADD 0,0
        if (!legal_s) begin
            dec_s.op      = OP_ADD;
            dec_s.in1     = '0;
            dec_s.in2     = '0;
            dec_s.wen     = 1'b0;
            dec_s.branch  = 1'b0;
            dec_s.jump    = 1'b0;
            dec_s.tgt     = '0;
            dec_s.illegal = 1'b1;
        end else begin
            dec_s.illegal = 1'b0;
        end
        if (dec_s.rd == 5'd0) begin
            dec_s.wen = 1'b0;
        end else begin
            dec_s.wen = dec_s.wen;
        end
    end

    assign if_ready   = !flush && (!ex_valid_q || ex_ready);
    assign transfer_s = if_valid && if_ready;

    // Pipeline register next state: flush beats transfer, payload only moves on transfer
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_d       = ex_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (transfer_s) begin
            ex_valid_d = 1'b1;
            ex_d       = dec_s;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end else begin
            ex_valid_d = ex_valid_q;
        end
    end

    // Pipeline register state
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_op      = ex_q.op;
    assign ex_in1     = ex_q.in1;
    assign ex_in2     = ex_q.in2;
    assign ex_rd      = ex_q.rd;
    assign ex_wen     = ex_q.wen;
    assign ex_branch  = ex_q.branch;
    assign ex_jump    = ex_q.jump;
    assign ex_tgt     = ex_q.tgt;
    assign ex_pc      = ex_q.pc;
    assign ex_illegal = ex_q.illegal;

endmodule

// File: tb/tb_rv32i_alu_issue.sv
// Self-checking bench for rv32i_alu_issue: expected bundles queued at offer time, compared after issue.
module tb_rv32i_alu_issue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_op;
    logic [31:0] ex_in1;
    logic [31:0] ex_in2;
    logic [4:0]  ex_rd;
    logic        ex_wen;
    logic        ex_branch;
    logic        ex_jump;
    logic [31:0] ex_tgt;
    logic [31:0] ex_pc;
    logic        ex_illegal;
`ifdef RV32I_ISSUE_BYPASS_EN
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`endif

    rv32i_alu_issue #(.XLEN(32), .OPW(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
`ifdef RV32I_ISSUE_BYPASS_EN
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
`endif
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_in1(ex_in1),
        .ex_in2(ex_in2), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_tgt(ex_tgt), .ex_pc(ex_pc), .ex_illegal(ex_illegal)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  rd;
        logic        wen;
        logic        br;
        logic        jp;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp;
    exp_t nxt_exp;
    bit   m_valid;
    int   n_pass;
    int   n_total;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic exp_t mk(input logic [3:0] op, input logic [31:0] in1, input logic [31:0] in2,
                                input logic [4:0] rd, input logic wen, input logic br, input logic jp,
                                input logic [31:0] tgt, input logic [31:0] pc, input logic ill);
        exp_t e;
        e.op = op; e.in1 = in1; e.in2 = in2; e.rd = rd; e.wen = wen;
        e.br = br; e.jp = jp; e.tgt = tgt; e.pc = pc; e.ill = ill;
        return e;
    endfunction

    task automatic check_outputs();
        check_val("ex_valid",   32'(ex_valid),   32'(m_valid));
        check_val("ex_op",      32'(ex_op),      32'(cur_exp.op));
        check_val("ex_in1",     ex_in1,          cur_exp.in1);
        check_val("ex_in2",     ex_in2,          cur_exp.in2);
        check_val("ex_rd",      32'(ex_rd),      32'(cur_exp.rd));
        check_val("ex_wen",     32'(ex_wen),     32'(cur_exp.wen));
        check_val("ex_branch",  32'(ex_branch),  32'(cur_exp.br));
        check_val("ex_jump",    32'(ex_jump),    32'(cur_exp.jp));
        check_val("ex_tgt",     ex_tgt,          cur_exp.tgt);
        check_val("ex_pc",      ex_pc,           cur_exp.pc);
        check_val("ex_illegal", 32'(ex_illegal), 32'(cur_exp.ill));
    endtask

    // One clock: check handshake, model the stage, check the registered bundle.
    task automatic cycle();
        bit rdy;
        bit xfer;
        #1;
        rdy  = !flush && (!m_valid || ex_ready);
        xfer = if_valid && rdy && !reset;
        check_val("if_ready", 32'(if_ready), 32'(rdy));
        if (if_valid) begin
            check_val("rs1_addr", 32'(rs1_addr), 32'(if_inst[19:15]));
            check_val("rs2_addr", 32'(rs2_addr), 32'(if_inst[24:20]));
        end
        if (xfer) exp_q.push_back(nxt_exp);
        @(posedge clk);
        #1;
        if (reset) begin
            m_valid = 1'b0;
            cur_exp = '0;
            exp_q.delete();
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (xfer) begin
            cur_exp = exp_q.pop_front();
            m_valid = 1'b1;
        end else if (ex_ready) begin
            m_valid = 1'b0;
        end
        check_outputs();
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input exp_t e);
        if_valid = 1'b1;
        if_inst  = inst;
        if_pc    = pc;
        rs1_data = r1;
        rs2_data = r2;
        nxt_exp  = e;
        cycle();
    endtask

    task automatic idle();
        if_valid = 1'b0;
        cycle();
    endtask

    initial begin
        n_pass = 0; n_total = 0; m_valid = 1'b0; cur_exp = '0; nxt_exp = '0;
        reset = 1'b1; flush = 1'b0; if_valid = 1'b0; if_inst = 32'h0; if_pc = 32'h0;
        rs1_data = 32'h0; rs2_data = 32'h0; ex_ready = 1'b1;
`ifdef RV32I_ISSUE_BYPASS_EN
        wb_wen = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
`endif
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b0;
        idle();

        // Decode coverage, back-to-back with ex_ready high
        offer(32'h002081B3, 32'h0,   32'd5, 32'd7,   mk(4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
        offer(32'h40435293, 32'h4,   32'h80000000, 32'h0, mk(4'd11, 32'h80000000, 32'd4, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 32'h4, 1'b0));
        offer(32'h20435293, 32'h8,   32'd1, 32'd2,   mk(4'd0, 32'h0, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 32'h0, 32'h8, 1'b1));
        offer(32'hFE20CCE3, 32'h100, 32'd3, 32'd9,   mk(4'd12, 32'd3, 32'd9, 5'd25, 1'b0, 1'b1, 1'b0, 32'hF8, 32'h100, 1'b0));
        offer(32'h00C100E7, 32'h200, 32'h203, 32'h77, mk(4'd0, 32'h200, 32'd4, 5'd1, 1'b1, 1'b0, 1'b1, 32'h20E, 32'h200, 1'b0));
        offer(32'h0100006F, 32'h300, 32'd1, 32'd2,   mk(4'd0, 32'h300, 32'd4, 5'd0, 1'b0, 1'b0, 1'b1, 32'h310, 32'h300, 1'b0));
        offer(32'hABCDE3B7, 32'h304, 32'd9, 32'd9,   mk(4'd0, 32'h0, 32'hABCDE000, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0, 32'h304, 1'b0));
        offer(32'h00001417, 32'h400, 32'd1, 32'd1,   mk(4'd0, 32'h400, 32'h1000, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0, 32'h400, 1'b0));
        offer(32'h0020A063, 32'h404, 32'd1, 32'd2,   mk(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h404, 1'b1));
        offer(32'h002081B0, 32'h408, 32'd1, 32'd2,   mk(4'd0, 32'h0, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h408, 1'b1));
        offer(32'h402081B3, 32'h40C, 32'd10, 32'd3,  mk(4'd10, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h40C, 1'b0));
        offer(32'hFFF00213, 32'h410, 32'd0, 32'd0,   mk(4'd0, 32'h0, 32'hFFFFFFFF, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h410, 1'b0));
        offer(32'h0020F063, 32'h414, 32'd1, 32'd2,   mk(4'd15, 32'd1, 32'd2, 5'd0, 1'b0, 1'b1, 1'b0, 32'h414, 32'h414, 1'b0));
        offer(32'h0F00C313, 32'h418, 32'h1234, 32'd0, mk(4'd4, 32'h1234, 32'hF0, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0, 32'h418, 1'b0));
        idle();
        idle();

        // Backpressure: outputs hold for three stalled cycles, then back-to-back issue
        offer(32'h002081B3, 32'h500, 32'd1, 32'd2,  mk(4'd0, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h500, 1'b0));
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(32'h40435293, 32'h504, 32'hF0000000, 32'd0, mk(4'd11, 32'hF0000000, 32'd4, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 32'h504, 1'b0));
        end
        ex_ready = 1'b1;
        offer(32'h40435293, 32'h504, 32'hF0000000, 32'd0, mk(4'd11, 32'hF0000000, 32'd4, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 32'h504, 1'b0));
        offer(32'h402081B3, 32'h508, 32'd4, 32'd9,   mk(4'd10, 32'd4, 32'd9, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h508, 1'b0));

        // Flush while a bundle is staged and fetch offers another
        flush = 1'b1;
        offer(32'hABCDE3B7, 32'h50C, 32'd0, 32'd0,   mk(4'd0, 32'h0, 32'hABCDE000, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0, 32'h50C, 1'b0));
        flush = 1'b0;
        idle();

        // Reset while a bundle is stalled discards it
        offer(32'h00C100E7, 32'h600, 32'h203, 32'h0, mk(4'd0, 32'h600, 32'd4, 5'd1, 1'b1, 1'b0, 1'b1, 32'h20E, 32'h600, 1'b0));
        ex_ready = 1'b0;
        reset = 1'b1;
        idle();
        reset = 1'b0;
        ex_ready = 1'b1;
        idle();

`ifdef RV32I_ISSUE_BYPASS_EN
        wb_wen = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
        offer(32'h002081B3, 32'h700, 32'd5, 32'd7,  mk(4'd0, 32'h55, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h700, 1'b0));
        wb_rd = 5'd2; wb_data = 32'h66;
        offer(32'h00C100E7, 32'h704, 32'h203, 32'h0, mk(4'd0, 32'h704, 32'd4, 5'd1, 1'b1, 1'b0, 1'b1, 32'h72, 32'h704, 1'b0));
        wb_wen = 1'b0;
        offer(32'h002081B3, 32'h708, 32'd5, 32'd7,  mk(4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 32'h708, 1'b0));
        idle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
